// File: rtl/dither_frame_sequencer_if.sv
// MCU byte handshake, frame RAM port and dithering-engine control, bundled
// as one interface. The sequencer takes the master view.
interface dither_frame_sequencer_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
);
    // MCU side
    logic                  mcu_tx_rdy;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  mcu_ack;
    logic                  mcu_rx_rdy;
    logic [DATA_WIDTH-1:0] tx_data;

    // Frame RAM port
    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Dithering engine control
    logic                  compute_start;
    logic                  compute_done;

    modport master (
        input  mcu_tx_rdy, rx_data, mcu_ack, ram_rdata, compute_done,
        output mcu_rx_rdy, tx_data, ram_we, ram_re, ram_addr, ram_wdata, compute_start
    );

    modport slave (
        output mcu_tx_rdy, rx_data, mcu_ack, ram_rdata, compute_done,
        input  mcu_rx_rdy, tx_data, ram_we, ram_re, ram_addr, ram_wdata, compute_start
    );
endinterface

// File: rtl/dither_frame_sequencer.sv
// Frame-level controller for the dithering datapath: loads one frame from the
// MCU into the frame RAM, starts the engine, watches it with a watchdog and
// streams the result back to the MCU one acknowledged byte at a time.
module dither_frame_sequencer #(
    parameter int unsigned IMAGEX           = 16,
    parameter int unsigned IMAGEY           = 16,
    parameter int unsigned IMAGE_SIZE       = IMAGEX * IMAGEY,
    parameter int unsigned IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE),
    parameter int unsigned RGB_SIZE         = 8,
    parameter int unsigned TIMEOUT_CYCLES   = 1048576
) (
    input  logic                     clk,
    input  logic                     rst,
    dither_frame_sequencer_if.master bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     error
);

    localparam int unsigned TimerWidth = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Explicit terminal counts so non-power-of-two frames wrap correctly.
    localparam logic [IMAGE_ADDR_WIDTH-1:0] LastAddr  = IMAGE_ADDR_WIDTH'(IMAGE_SIZE - 1);
    localparam logic [TimerWidth-1:0]       TimerLast = TimerWidth'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        StIdle,
        StLoad,
        StWrite,
        StKick,
        StCompute,
        StFetch,
        StLatch,
        StPresent,
        StFinish,
        StError
    } state_e;

    state_e                      state_q, state_d;
    logic [IMAGE_ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
    logic [IMAGE_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [TimerWidth-1:0]       timer_q, timer_d;
    logic [RGB_SIZE-1:0]         wdata_q, wdata_d;
    logic [RGB_SIZE-1:0]         tx_data_q, tx_data_d;

    logic [1:0] tx_sync_q;
    logic       tx_prev_q;
    logic [1:0] ack_sync_q;
    logic       ack_prev_q;
    logic       tx_edge;
    logic       ack_edge;

    // MCU strobes are asynchronous: two-flop synchronise, then keep the
    // previous synchronised level so only rising edges become events.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_sync_q  <= '0;
            tx_prev_q  <= 1'b0;
            ack_sync_q <= '0;
            ack_prev_q <= 1'b0;
        end else begin
            tx_sync_q  <= {tx_sync_q[0], bus.mcu_tx_rdy};
            tx_prev_q  <= tx_sync_q[1];
            ack_sync_q <= {ack_sync_q[0], bus.mcu_ack};
            ack_prev_q <= ack_sync_q[1];
        end
    end

    assign tx_edge  = tx_sync_q[1] & ~tx_prev_q;
    assign ack_edge = ack_sync_q[1] & ~ack_prev_q;

    // State, counters, watchdog timer and data holding registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            timer_q   <= '0;
            wdata_q   <= '0;
            tx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            timer_q   <= timer_d;
            wdata_q   <= wdata_d;
            tx_data_q <= tx_data_d;
        end
    end

    // Next-state logic and per-state outputs; edges are only honoured in the
    // states that expect them, so stray strobes are dropped, never queued.
    always_comb begin
        state_d           = state_q;
        wr_cnt_d          = wr_cnt_q;
        rd_cnt_d          = rd_cnt_q;
        timer_d           = timer_q;
        wdata_d           = wdata_q;
        tx_data_d         = tx_data_q;
        bus.mcu_rx_rdy    = 1'b0;
        bus.ram_we        = 1'b0;
        bus.ram_re        = 1'b0;
        bus.ram_addr      = '0;
        bus.compute_start = 1'b0;
        busy              = 1'b1;
        frame_done        = 1'b0;
        error             = 1'b0;

        unique case (state_q)
            StIdle, StLoad: begin
                bus.mcu_rx_rdy = 1'b1;
                busy           = (state_q == StLoad);
                if (tx_edge) begin
                    wdata_d = bus.rx_data;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                bus.ram_we   = 1'b1;
                bus.ram_addr = wr_cnt_q;
                if (wr_cnt_q == LastAddr) begin
                    wr_cnt_d = '0;
                    state_d  = StKick;
                end else begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    state_d  = StLoad;
                end
            end
            StKick: begin
                bus.compute_start = 1'b1;
                timer_d           = '0;
                state_d           = StCompute;
            end
            StCompute: begin
                timer_d = timer_q + 1'b1;
                // Done takes priority over a coincident watchdog expiry.
                if (bus.compute_done) begin
                    state_d = StFetch;
                end else if (timer_q == TimerLast) begin
                    state_d = StError;
                end
            end
            StFetch: begin
                bus.ram_re   = 1'b1;
                bus.ram_addr = rd_cnt_q;
                state_d      = StLatch;
            end
            StLatch: begin
                tx_data_d = bus.ram_rdata;
                state_d   = StPresent;
            end
            StPresent: begin
                bus.mcu_rx_rdy = 1'b1;
                if (ack_edge) begin
                    bus.mcu_rx_rdy = 1'b0;
                    if (rd_cnt_q == LastAddr) begin
                        rd_cnt_d = '0;
                        state_d  = StFinish;
                    end else begin
                        rd_cnt_d = rd_cnt_q + 1'b1;
                        state_d  = StFetch;
                    end
                end
            end
            StFinish: begin
                frame_done = 1'b1;
                state_d    = StIdle;
            end
            StError: begin
                // Sticky; only reset leaves this state.
                error = 1'b1;
                busy  = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.tx_data   = tx_data_q;
    assign bus.ram_wdata = wdata_q;

endmodule

// File: tb/tb_dither_frame_sequencer.sv
// Directed bench for dither_frame_sequencer on a 4x4 frame with a 100-cycle
// watchdog: load, compute, unload, mid-load reset, timeout and done-vs-timeout.
module tb_dither_frame_sequencer;

    localparam int unsigned IMAGEX     = 4;
    localparam int unsigned IMAGEY     = 4;
    localparam int unsigned IMAGE_SIZE = 16;
    localparam int unsigned AW         = 4;
    localparam int unsigned DW         = 8;
    localparam int unsigned TIMEOUT    = 100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic frame_done;
    logic error;

    always #5 clk = ~clk;

    dither_frame_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    dither_frame_sequencer #(
        .IMAGEX        (IMAGEX),
        .IMAGEY        (IMAGEY),
        .RGB_SIZE      (DW),
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done),
        .error     (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Frame RAM model; a done pulse stands for the engine rewriting the frame
    // with an alternating FF/00 pattern.
    logic [DW-1:0] mem [IMAGE_SIZE];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        if (bus.compute_done) begin
            for (int i = 0; i < int'(IMAGE_SIZE); i++) mem[i] <= (i % 2 == 0) ? 8'hFF : 8'h00;
        end
        if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
    end

    // Passive monitor.
    int            we_cnt = 0;
    int            re_cnt = 0;
    int            kick_cnt = 0;
    int            fd_cnt = 0;
    int            compute_cyc = 0;
    int            strobe_viol = 0;
    logic [AW-1:0] wr_addr_log [$];
    logic [DW-1:0] wr_data_log [$];

    always @(negedge clk) begin
        if (rst) begin
            if (bus.ram_we) begin
                we_cnt++;
                wr_addr_log.push_back(bus.ram_addr);
                wr_data_log.push_back(bus.ram_wdata);
            end
            if (bus.ram_re) re_cnt++;
            if (frame_done) fd_cnt++;
            if (bus.compute_start) begin
                kick_cnt++;
                compute_cyc = 0;
            end else if (busy && !bus.mcu_rx_rdy && !bus.ram_we && !bus.ram_re) begin
                compute_cyc++;
            end
            if (bus.ram_we && bus.ram_re) strobe_viol++;
            if (!bus.ram_we && !bus.ram_re && bus.ram_addr != '0) strobe_viol++;
        end
    end

    // Engine model: pulses done eng_delay cycles into COMPUTE.
    logic eng_en    = 1'b0;
    int   eng_delay = 50;

    initial begin
        bus.compute_done = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.compute_start && eng_en) begin
                repeat (eng_delay) @(negedge clk);
                if (eng_delay == int'(TIMEOUT)) begin
                    check_eq("last_cycle_no_error", 32'(error), 32'd0);
                end
                bus.compute_done = 1'b1;
                @(negedge clk);
                bus.compute_done = 1'b0;
                if (eng_delay == int'(TIMEOUT)) begin
                    check_eq("done_wins_fetch", 32'(bus.ram_re), 32'd1);
                    check_eq("done_wins_error", 32'(error), 32'd0);
                end
            end
        end
    end

    task automatic send_byte(input logic [DW-1:0] d, output int lat);
        bus.rx_data = d;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            if (k == 1) bus.mcu_tx_rdy = 1'b1;
            if (k == 5) bus.mcu_tx_rdy = 1'b0;
            @(negedge clk);
            if (bus.ram_we && lat < 0) lat = k;
        end
    endtask

    task automatic pulse_ack();
        bus.mcu_ack = 1'b1;
        repeat (4) @(negedge clk);
        bus.mcu_ack = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rdy(input string tag, input int budget);
        for (int k = 0; k < budget && !bus.mcu_rx_rdy; k++) @(negedge clk);
        check_eq(tag, 32'(bus.mcu_rx_rdy), 32'd1);
    endtask

    task automatic check_frame(input int base, input logic [DW-1:0] first);
        for (int i = 0; i < int'(IMAGE_SIZE); i++) begin
            check_eq("write_addr_data", {24'd0, wr_addr_log[base + i], wr_data_log[base + i]},
                     {24'd0, AW'(i), DW'(first + DW'(i))});
        end
    endtask

    initial begin
        int lat;
        int base_we;
        int base_re;
        int base_kick;
        int base_fd;

        bus.mcu_tx_rdy = 1'b0;
        bus.rx_data    = '0;
        bus.mcu_ack    = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_eq("rst_rx_rdy", 32'(bus.mcu_rx_rdy), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_error", 32'(error), 32'd0);
        check_eq("rst_strobes", {29'd0, bus.ram_we, bus.ram_re, bus.compute_start}, 32'd0);
        check_eq("rst_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst_tx_data", 32'(bus.tx_data), 32'd0);
        check_eq("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Frame 1: load 0x00..0x0F, stray tx edges during COMPUTE.
        eng_en    = 1'b1;
        eng_delay = 50;
        base_we   = we_cnt;
        base_kick = kick_cnt;
        base_fd   = fd_cnt;
        send_byte(8'h00, lat);
        check_eq("tx_to_we_latency", 32'(lat), 32'd3);
        for (int i = 1; i < int'(IMAGE_SIZE); i++) send_byte(DW'(i), lat);
        send_byte(8'hAA, lat);
        send_byte(8'hBB, lat);
        check_eq("load_write_count", 32'(we_cnt - base_we), 32'd16);
        check_eq("kick_count", 32'(kick_cnt - base_kick), 32'd1);
        check_frame(base_we, 8'h00);

        // Unload; ack held high across several cycles advances one byte only.
        base_re = re_cnt;
        wait_rdy("present_0", 200);
        check_eq("tx_byte_0", 32'(bus.tx_data), 32'hFF);
        bus.mcu_ack = 1'b1;
        repeat (30) @(negedge clk);
        check_eq("ack_hold_rdy", 32'(bus.mcu_rx_rdy), 32'd1);
        check_eq("ack_hold_data", 32'(bus.tx_data), 32'h00);
        check_eq("ack_hold_reads", 32'(re_cnt - base_re), 32'd2);
        bus.mcu_ack = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 1; i < int'(IMAGE_SIZE); i++) begin
            wait_rdy("present_n", 50);
            check_eq("tx_byte_n", 32'(bus.tx_data), (i % 2 == 0) ? 32'hFF : 32'h00);
            pulse_ack();
        end
        repeat (4) @(negedge clk);
        check_eq("frame_done_count", 32'(fd_cnt - base_fd), 32'd1);
        check_eq("idle_rx_rdy", 32'(bus.mcu_rx_rdy), 32'd1);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("unload_reads", 32'(re_cnt - base_re), 32'd16);
        check_eq("write_count_after_unload", 32'(we_cnt - base_we), 32'd16);

        // Frame 2: reset after 7 bytes, then reload from address 0.
        eng_en  = 1'b0;
        base_we = we_cnt;
        for (int i = 0; i < 7; i++) send_byte(8'h40 + DW'(i), lat);
        check_eq("partial_writes", 32'(we_cnt - base_we), 32'd7);
        rst = 1'b0;
        #1;
        check_eq("midrst_rx_rdy", 32'(bus.mcu_rx_rdy), 32'd1);
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_wdata", 32'(bus.ram_wdata), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base_we = we_cnt;
        for (int i = 0; i < int'(IMAGE_SIZE); i++) send_byte(8'h20 + DW'(i), lat);
        check_eq("reload_write_count", 32'(we_cnt - base_we), 32'd16);
        check_frame(base_we, 8'h20);

        // Watchdog: engine silent.
        for (int k = 0; k < 400 && !error; k++) @(negedge clk);
        check_eq("timeout_error", 32'(error), 32'd1);
        repeat (2) @(negedge clk);
        check_eq("timeout_compute_cycles", 32'(compute_cyc), 32'd100);
        check_eq("error_busy", 32'(busy), 32'd0);
        check_eq("error_rx_rdy", 32'(bus.mcu_rx_rdy), 32'd0);
        base_we = we_cnt;
        base_re = re_cnt;
        send_byte(8'h55, lat);
        send_byte(8'h66, lat);
        pulse_ack();
        check_eq("error_no_writes", 32'(we_cnt - base_we), 32'd0);
        check_eq("error_no_reads", 32'(re_cnt - base_re), 32'd0);
        check_eq("error_sticky", 32'(error), 32'd1);

        // Frame 3: done arrives in the final watchdog cycle.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        eng_en    = 1'b1;
        eng_delay = int'(TIMEOUT);
        for (int i = 0; i < int'(IMAGE_SIZE); i++) send_byte(8'h30 + DW'(i), lat);
        wait_rdy("late_done_present", 300);
        check_eq("late_done_data", 32'(bus.tx_data), 32'hFF);
        check_eq("late_done_error", 32'(error), 32'd0);

        check_eq("strobe_exclusive", 32'(strobe_viol), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Global guard against a hung run.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
